// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID/EX hazard sources and interrupt lines in, stall/flush/redirect controls out.
// master = pipeline datapath side, slave = the hazard controller.
interface pipeline_hazard_ctrl_if;
   logic [4:0]  ID_rs1;
   logic [4:0]  ID_rs2;
   logic        ID_use_rs1;
   logic        ID_use_rs2;
   logic [31:0] ID_pc;
   logic [4:0]  EX_rd;
   logic        EX_MemRead;
   logic        EX_branch_taken;
   logic        EX_mret;
   logic        irq;
   logic        irq_enable;
   logic        PC_write;
   logic        IF_ID_write;
   logic        IF_ID_flush;
   logic        ID_EX_flush;
   logic [1:0]  PC_src;
   logic        irq_ack;
   logic        in_isr;
   logic [31:0] epc;

   modport master (
      output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_pc,
      output EX_rd, EX_MemRead, EX_branch_taken, EX_mret, irq, irq_enable,
      input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, PC_src, irq_ack, in_isr, epc
   );

   modport slave (
      input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_pc,
      input  EX_rd, EX_MemRead, EX_branch_taken, EX_mret, irq, irq_enable,
      output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, PC_src, irq_ack, in_isr, epc
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/redirect control for the 5-stage core: load-use stall, taken-branch squash, irq entry and mret return.
// Controls are combinational from state + inputs (0 cycles); irq entry takes DRAIN_CYCLES+1 cycles to irq_ack; backpressure is the stall itself.
module pipeline_hazard_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter logic [31:0] ISR_VECTOR   = 32'h0000_0100
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_hazard_ctrl_if.slave hazardBus
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      VECTOR = 2'd2,
      ISR    = 2'd3
   } stateT;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_VECTOR = 2'b10;
   localparam logic [1:0] PC_EPC    = 2'b11;
   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

   stateT       stateQ, stateD;
   logic [3:0]  cntQ, cntD;
   logic        inIsrQ, inIsrD;
   logic [31:0] epcQ, epcD;

   logic        loadUse;
   logic        pcWrite, ifIdWrite, ifIdFlush, idExFlush, irqAck;
   logic [1:0]  pcSrc;

   // x0 is never a real producer, so a load into x0 cannot create a hazard.
   assign loadUse = hazardBus.EX_MemRead && (hazardBus.EX_rd != 5'd0) &&
                    ((hazardBus.ID_use_rs1 && (hazardBus.ID_rs1 == hazardBus.EX_rd)) ||
                     (hazardBus.ID_use_rs2 && (hazardBus.ID_rs2 == hazardBus.EX_rd)));

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= RUN;
         cntQ   <= 4'd0;
         inIsrQ <= 1'b0;
         epcQ   <= 32'd0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         inIsrQ <= inIsrD;
         epcQ   <= epcD;
      end
   end

   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      inIsrD    = inIsrQ;
      epcD      = epcQ;
      pcWrite   = 1'b1;
      ifIdWrite = 1'b1;
      ifIdFlush = 1'b0;
      idExFlush = 1'b0;
      pcSrc     = PC_SEQ;
      irqAck    = 1'b0;

      unique case (stateQ)
         RUN: begin
            if (hazardBus.EX_branch_taken) begin
               pcSrc     = PC_BRANCH;
               ifIdFlush = 1'b1;
               idExFlush = 1'b1;
            end else if (hazardBus.irq && hazardBus.irq_enable) begin
               // The ID instruction is squashed here and replayed from epc on return.
               epcD      = hazardBus.ID_pc;
               pcWrite   = 1'b0;
               ifIdFlush = 1'b1;
               idExFlush = 1'b1;
               cntD      = DRAIN_INIT;
               stateD    = DRAIN;
            end else if (loadUse) begin
               pcWrite   = 1'b0;
               ifIdWrite = 1'b0;
               idExFlush = 1'b1;
            end
         end

         DRAIN: begin
            pcWrite   = 1'b0;
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
            if (cntQ == 4'd0) begin
               stateD = VECTOR;
            end else begin
               cntD = cntQ - 4'd1;
            end
         end

         VECTOR: begin
            pcSrc     = PC_VECTOR;
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
            irqAck    = 1'b1;
            inIsrD    = 1'b1;
            stateD    = ISR;
         end

         ISR: begin
            if (hazardBus.EX_mret) begin
               pcSrc     = PC_EPC;
               ifIdFlush = 1'b1;
               idExFlush = 1'b1;
               inIsrD    = 1'b0;
               stateD    = RUN;
            end else if (hazardBus.EX_branch_taken) begin
               pcSrc     = PC_BRANCH;
               ifIdFlush = 1'b1;
               idExFlush = 1'b1;
            end else if (loadUse) begin
               pcWrite   = 1'b0;
               ifIdWrite = 1'b0;
               idExFlush = 1'b1;
            end
         end

         default: stateD = RUN;
      endcase
   end

   assign hazardBus.PC_write    = pcWrite;
   assign hazardBus.IF_ID_write = ifIdWrite;
   assign hazardBus.IF_ID_flush = ifIdFlush;
   assign hazardBus.ID_EX_flush = idExFlush;
   assign hazardBus.PC_src      = pcSrc;
   assign hazardBus.irq_ack     = irqAck;
   assign hazardBus.in_isr      = inIsrQ;
   assign hazardBus.epc         = epcQ;

   // The vector fetch must be word aligned and the drain count must fit the 4-bit counter.
   assert property (@(posedge clk) disable iff (rst)
      (DRAIN_CYCLES >= 1) && (DRAIN_CYCLES <= 15) && (ISR_VECTOR[1:0] == 2'b00));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with DRAIN_CYCLES = 3.
module tb_pipeline_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   pipeline_hazard_ctrl_if hazardBus ();

   pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .ISR_VECTOR(32'h0000_0100)) dut (
      .clk       (clk),
      .rst       (rst),
      .hazardBus (hazardBus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hazardBus.ID_rs1 = 5'd0;          hazardBus.ID_rs2 = 5'd0;
      hazardBus.ID_use_rs1 = 1'b0;      hazardBus.ID_use_rs2 = 1'b0;
      hazardBus.ID_pc = 32'h0;          hazardBus.EX_rd = 5'd0;
      hazardBus.EX_MemRead = 1'b0;      hazardBus.EX_branch_taken = 1'b0;
      hazardBus.EX_mret = 1'b0;         hazardBus.irq = 1'b0;
      hazardBus.irq_enable = 1'b0;
   endtask

   task automatic set_load_use();
      hazardBus.EX_MemRead = 1'b1;
      hazardBus.EX_rd      = 5'd5;
      hazardBus.ID_rs1     = 5'd5;
      hazardBus.ID_use_rs1 = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      #1;
      checks++; if (hazardBus.in_isr !== 1'b0) begin errors++; $display("FAIL reset_in_isr got %0h want 0", hazardBus.in_isr); end
      checks++; if (hazardBus.epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %0h want 0", hazardBus.epc); end
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.PC_src, hazardBus.irq_ack} !== 7'b1100_000)
         begin errors++; $display("FAIL reset_ctrl got %b want 1100000", {hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.PC_src, hazardBus.irq_ack}); end
   endtask

   task automatic test_load_use();
      idle_inputs();
      set_load_use();
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush} !== 4'b0001)
         begin errors++; $display("FAIL lu_rs1_stall got %b want 0001", {hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush}); end
      hazardBus.EX_rd = 5'd0; hazardBus.ID_rs1 = 5'd0;
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.ID_EX_flush} !== 3'b110)
         begin errors++; $display("FAIL lu_x0_nostall got %b want 110", {hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.ID_EX_flush}); end
      set_load_use();
      hazardBus.ID_use_rs1 = 1'b0;
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.ID_EX_flush} !== 3'b110)
         begin errors++; $display("FAIL lu_unused_nostall got %b want 110", {hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.ID_EX_flush}); end
      hazardBus.ID_rs2 = 5'd5; hazardBus.ID_use_rs2 = 1'b1;
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.ID_EX_flush} !== 3'b001)
         begin errors++; $display("FAIL lu_rs2_stall got %b want 001", {hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.ID_EX_flush}); end
      hazardBus.EX_MemRead = 1'b0;
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.ID_EX_flush} !== 3'b110)
         begin errors++; $display("FAIL lu_notload_nostall got %b want 110", {hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.ID_EX_flush}); end
      // Stall cycle followed by the bubble in EX: the stall must clear.
      set_load_use();
      step();
      hazardBus.EX_MemRead = 1'b0; hazardBus.EX_rd = 5'd0;
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.ID_EX_flush} !== 3'b110)
         begin errors++; $display("FAIL lu_one_cycle got %b want 110", {hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.ID_EX_flush}); end
      idle_inputs();
   endtask

   task automatic test_branch_over_lu();
      idle_inputs();
      set_load_use();
      hazardBus.EX_branch_taken = 1'b1;
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.PC_src} !== 6'b1111_01)
         begin errors++; $display("FAIL branch_over_lu got %b want 111101", {hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.PC_src}); end
      idle_inputs();
   endtask

   task automatic test_masking();
      idle_inputs();
      hazardBus.irq = 1'b1; hazardBus.ID_pc = 32'h80;
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush} !== 3'b100)
         begin errors++; $display("FAIL mask_ctrl got %b want 100", {hazardBus.PC_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush}); end
      step(); step();
      checks++; if ({hazardBus.in_isr, hazardBus.irq_ack, hazardBus.PC_write} !== 3'b001 || hazardBus.epc !== 32'h0)
         begin errors++; $display("FAIL mask_state got in_isr/ack/pcw=%b epc=%0h want 001 epc=0", {hazardBus.in_isr, hazardBus.irq_ack, hazardBus.PC_write}, hazardBus.epc); end
      hazardBus.irq_enable = 1'b1; hazardBus.EX_branch_taken = 1'b1;
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.PC_src, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush} !== 5'b1_01_11)
         begin errors++; $display("FAIL irq_vs_branch got %b want 10111", {hazardBus.PC_write, hazardBus.PC_src, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush}); end
      step();
      checks++; if (hazardBus.epc !== 32'h0) begin errors++; $display("FAIL irq_vs_branch_epc got %0h want 0", hazardBus.epc); end
      hazardBus.EX_branch_taken = 1'b0; hazardBus.ID_pc = 32'h84;
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.PC_src} !== 6'b0111_00)
         begin errors++; $display("FAIL irq_after_branch got %b want 011100", {hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.PC_src}); end
      step();
      checks++; if (hazardBus.epc !== 32'h84) begin errors++; $display("FAIL irq_after_branch_epc got %0h want 84", hazardBus.epc); end
      idle_inputs();
      rst = 1'b1; step(); rst = 1'b0;
   endtask

   task automatic test_irq_entry();
      idle_inputs();
      set_load_use();
      hazardBus.irq = 1'b1; hazardBus.irq_enable = 1'b1; hazardBus.ID_pc = 32'h40;
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.irq_ack} !== 5'b01110)
         begin errors++; $display("FAIL accept_over_lu got %b want 01110", {hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.irq_ack}); end
      step();
      checks++; if (hazardBus.epc !== 32'h40) begin errors++; $display("FAIL entry_epc got %0h want 40", hazardBus.epc); end
      // irq drops and EX noise appears while draining; entry must proceed regardless.
      idle_inputs();
      hazardBus.EX_branch_taken = 1'b1; hazardBus.EX_mret = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         #1;
         checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.PC_src, hazardBus.irq_ack} !== 6'b011_00_0)
            begin errors++; $display("FAIL drain_cycle%0d got %b want 011000", k, {hazardBus.PC_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.PC_src, hazardBus.irq_ack}); end
         step();
      end
      hazardBus.EX_branch_taken = 1'b0; hazardBus.EX_mret = 1'b0;
      #1;
      checks++; if ({hazardBus.irq_ack, hazardBus.PC_src, hazardBus.PC_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.in_isr} !== 7'b1_10_111_0)
         begin errors++; $display("FAIL vector_cycle got %b want 1101110", {hazardBus.irq_ack, hazardBus.PC_src, hazardBus.PC_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.in_isr}); end
      step();
      checks++; if ({hazardBus.in_isr, hazardBus.irq_ack, hazardBus.PC_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush} !== 5'b10100)
         begin errors++; $display("FAIL isr_entered got %b want 10100", {hazardBus.in_isr, hazardBus.irq_ack, hazardBus.PC_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush}); end
   endtask

   task automatic test_isr_and_return();
      idle_inputs();
      hazardBus.irq = 1'b1; hazardBus.irq_enable = 1'b1; hazardBus.ID_pc = 32'h1234;
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush} !== 3'b100)
         begin errors++; $display("FAIL isr_nested_irq got %b want 100", {hazardBus.PC_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush}); end
      step();
      checks++; if (hazardBus.in_isr !== 1'b1 || hazardBus.epc !== 32'h40)
         begin errors++; $display("FAIL isr_nested_state got in_isr=%0h epc=%0h want 1 epc=40", hazardBus.in_isr, hazardBus.epc); end
      idle_inputs();
      set_load_use();
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.ID_EX_flush} !== 3'b001)
         begin errors++; $display("FAIL isr_lu got %b want 001", {hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.ID_EX_flush}); end
      hazardBus.EX_branch_taken = 1'b1;
      #1;
      checks++; if ({hazardBus.PC_src, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.PC_write} !== 5'b01_11_1)
         begin errors++; $display("FAIL isr_branch got %b want 01111", {hazardBus.PC_src, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.PC_write}); end
      hazardBus.EX_mret = 1'b1;
      #1;
      checks++; if ({hazardBus.PC_src, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.in_isr} !== 7'b11_11_111)
         begin errors++; $display("FAIL mret_redirect got %b want 1111111", {hazardBus.PC_src, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush, hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.in_isr}); end
      idle_inputs();
      hazardBus.EX_mret = 1'b1;
      step();
      checks++; if ({hazardBus.in_isr, hazardBus.PC_src, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush} !== 5'b0_00_00)
         begin errors++; $display("FAIL mret_in_run got %b want 00000", {hazardBus.in_isr, hazardBus.PC_src, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush}); end
      step();
      checks++; if (hazardBus.in_isr !== 1'b0 || hazardBus.epc !== 32'h40)
         begin errors++; $display("FAIL after_return got in_isr=%0h epc=%0h want 0 epc=40", hazardBus.in_isr, hazardBus.epc); end
      idle_inputs();
   endtask

   task automatic test_reset_mid_drain();
      int ackSeen;
      idle_inputs();
      hazardBus.irq = 1'b1; hazardBus.irq_enable = 1'b1; hazardBus.ID_pc = 32'h200;
      step();
      checks++; if (hazardBus.epc !== 32'h200) begin errors++; $display("FAIL drain_epc got %0h want 200", hazardBus.epc); end
      idle_inputs();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++; if ({hazardBus.in_isr, hazardBus.irq_ack, hazardBus.PC_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush} !== 5'b00100 || hazardBus.epc !== 32'h0)
         begin errors++; $display("FAIL rst_mid_drain got %b epc=%0h want 00100 epc=0", {hazardBus.in_isr, hazardBus.irq_ack, hazardBus.PC_write, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush}, hazardBus.epc); end
      ackSeen = 0;
      for (int k = 0; k < 6; k++) begin
         if (hazardBus.irq_ack === 1'b1) ackSeen++;
         step();
      end
      checks++; if (ackSeen !== 0 || hazardBus.in_isr !== 1'b0)
         begin errors++; $display("FAIL rst_no_ack got acks=%0d in_isr=%0h want 0 0", ackSeen, hazardBus.in_isr); end
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      set_load_use();
      step();
      hazardBus.EX_MemRead = 1'b0; hazardBus.EX_rd = 5'd0; hazardBus.EX_branch_taken = 1'b1;
      #1;
      checks++; if ({hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.PC_src, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush} !== 6'b11_01_11)
         begin errors++; $display("FAIL b2b_lu_then_branch got %b want 110111", {hazardBus.PC_write, hazardBus.IF_ID_write, hazardBus.PC_src, hazardBus.IF_ID_flush, hazardBus.ID_EX_flush}); end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_load_use();
      test_branch_over_lu();
      test_masking();
      test_irq_entry();
      test_isr_and_return();
      test_reset_mid_drain();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush/redirect controller for the 5-stage pipelined CPU. It detects load-use hazards that forwarding cannot cover, squashes wrong-path instructions after a taken branch or jump resolves in EX, and sequences external-interrupt entry and `mret` return. To do this it drives the PC-write, IF/ID and ID/EX pipeline-register controls and the PC source mux.

## Interface
- `DRAIN_CYCLES`, default 3: bubble cycles inserted after interrupt acceptance so EX/MEM/WB retire before the vector fetch. Legal range is 1..15.
- `ISR_VECTOR`, default 32'h0000_0100: informational only. The vector address itself is produced by the PC mux.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `ID_rs1`, input, 5: rs1 field of the instruction in ID.
- `ID_rs2`, input, 5: rs2 field of the instruction in ID.
- `ID_use_rs1`, input, 1: the instruction in ID actually reads rs1.
- `ID_use_rs2`, input, 1: the instruction in ID actually reads rs2.
- `ID_pc`, input, 32: PC of the instruction in ID.
- `EX_rd`, input, 5: destination register of the instruction in EX.
- `EX_MemRead`, input, 1: the instruction in EX is a load.
- `EX_branch_taken`, input, 1: a branch or jump in EX resolved taken.
- `EX_mret`, input, 1: the instruction in EX is `mret`.
- `irq`, input, 1: external interrupt request, level-sensitive.
- `irq_enable`, input, 1: global interrupt enable from the CSR.
- `PC_write`, output, 1: PC register load enable.
- `IF_ID_write`, output, 1: IF/ID register load enable.
- `IF_ID_flush`, output, 1: load a bubble (NOP) into IF/ID.
- `ID_EX_flush`, output, 1: load a bubble into ID/EX.
- `PC_src`, output, 2: PC source select. 00 = PC+4, 01 = branch target, 10 = ISR vector, 11 = `epc`.
- `irq_ack`, output, 1: one-cycle pulse when the vector fetch is issued.
- `in_isr`, output, 1: the core is executing the ISR. Registered.
- `epc`, output, 32: saved return PC. Registered.

## Operation
- Load-use hazard `lu` is true when all of the following hold:
  - `EX_MemRead` = 1;
  - `EX_rd` ≠ 0;
  - (`ID_use_rs1` & `ID_rs1`==`EX_rd`) | (`ID_use_rs2` & `ID_rs2`==`EX_rd`).
- FSM states: RUN, DRAIN, VECTOR, ISR. The reset state is RUN.
- Defaults in every state unless overridden:
  - `PC_write`=1, `IF_ID_write`=1;
  - both flushes = 0, `PC_src`=00, `irq_ack`=0.
- RUN, evaluated in priority order:
  1. `EX_branch_taken`: `PC_src`=01, `IF_ID_flush`=1, `ID_EX_flush`=1. Stay in RUN.
  2. Interrupt accept, when `irq` & `irq_enable` (and no branch taken):
     - `epc` <= `ID_pc`, so the ID instruction is squashed and later re-executed;
     - `PC_write`=0, `IF_ID_flush`=1, `ID_EX_flush`=1;
     - counter <= `DRAIN_CYCLES`-1, go to DRAIN.
     - Interrupt accept overrides `lu`.
  3. `lu`: `PC_write`=0, `IF_ID_write`=0, `ID_EX_flush`=1 for exactly the cycle `lu` is true. Stay in RUN.
  - `EX_mret` in RUN is ignored (no redirect, no state change).
- DRAIN:
  - `PC_write`=0, `IF_ID_flush`=1, `ID_EX_flush`=1;
  - counter decrements each cycle; at counter==0 go to VECTOR;
  - `irq` deasserting here does not cancel entry (the request is already committed);
  - all EX-stage inputs are ignored.
- VECTOR:
  - `PC_src`=10, `PC_write`=1, `IF_ID_flush`=1, `ID_EX_flush`=1, `irq_ack`=1;
  - `in_isr` <= 1, go to ISR.
- ISR:
  - Hazard handling is identical to RUN items 1 and 3.
  - `irq` is ignored (no nesting).
  - On `EX_mret`: `PC_src`=11, `IF_ID_flush`=1, `ID_EX_flush`=1, `in_isr` <= 0, go to RUN. `EX_mret` has priority over `EX_branch_taken`.
- `epc` changes only on interrupt accept.

## Timing
- Stall, flush, `PC_src` and `irq_ack` are combinational from the current state and inputs, valid in the same cycle.
- State, counter, `in_isr` and `epc` update on the rising `clk` edge.
- Reset (`rst`=1 at an edge):
  - state = RUN, counter = 0, `in_isr` = 0, `epc` = 0;
  - after reset the outputs are the RUN decode of the current inputs.
- Reset is honoured mid-DRAIN and mid-ISR: the next cycle is RUN with no `irq_ack`.
- Interrupt latency, from the accept cycle to the `irq_ack` cycle, is exactly `DRAIN_CYCLES`+1 cycles.
- A load-use stall lasts one cycle. The ID instruction is held and the dependent operand is forwarded from MEM/WB the next cycle.

## Test plan
- **Load-use:** `EX_MemRead`=1, `EX_rd`=5, `ID_rs1`=5, `ID_use_rs1`=1 → `PC_write`=0, `IF_ID_write`=0, `ID_EX_flush`=1 for one cycle. With `EX_rd`=0, or with `ID_use_rs1`=0, there is no stall.
- **Branch over load-use:** `EX_branch_taken`=1 together with a load-use condition → `PC_src`=01, both flushes = 1, `PC_write`=1.
- **Interrupt entry:** `irq`=1, `irq_enable`=1, `ID_pc`=0x40, `DRAIN_CYCLES`=3 →
  - `epc`=0x40;
  - `irq_ack` exactly 4 cycles after the accept cycle, with `PC_src`=10;
  - then `in_isr`=1;
  - `irq` deasserted during DRAIN does not alter the result.
- **Masking:**
  - `irq`=1 with `irq_enable`=0 → no state change;
  - `irq`=1 with `EX_branch_taken`=1 → the branch is handled, and the interrupt is taken the next cycle if still pending.
- **Return:** `EX_mret`=1 in ISR → `PC_src`=11, both flushes, `in_isr`=0 next cycle. `EX_mret` in RUN → no effect. A second `irq` while in ISR → ignored.
- **Reset mid-DRAIN:** `rst` pulsed during DRAIN → RUN next cycle, `irq_ack` never asserts, `epc`=0.
